// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes one instruction into ALU opcode and operands
// and holds it in a single valid/ready output register.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_control,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned RA_W  = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b1001;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RA_W-1:0] rd_field;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic            take;

    logic [ALU_W-1:0] dec_alu;
    logic [XLEN-1:0]  dec_a;
    logic [XLEN-1:0]  dec_b;
    logic             dec_ill;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rd_field = instr[11:7];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};
    assign shamt = XLEN'(instr[24:20]);

    assign in_ready = rst_n && (!out_valid || out_ready);
    assign take     = in_valid && in_ready;

    // funct3 to ALU opcode for the base (funct7 = 0) register/immediate forms
    function automatic logic [ALU_W-1:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    // Instruction decode; anything unrecognised stays illegal with zero operands
    always_comb begin
        dec_alu = ALU_ADD;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                if (funct7 == F7_BASE) begin
                    dec_ill = 1'b0;
                    dec_alu = base_alu(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_ill = 1'b0;
                    dec_alu = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_ill = 1'b0;
                    dec_alu = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                dec_a = rs1_data;
                case (funct3)
                    3'b001: begin
                        dec_b   = shamt;
                        dec_alu = ALU_SLL;
                        dec_ill = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        dec_b   = shamt;
                        dec_alu = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_ill = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                    default: begin
                        dec_b   = imm_i;
                        dec_alu = base_alu(funct3);
                        dec_ill = 1'b0;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_b   = imm_u;
                dec_ill = 1'b0;
            end
            OPC_AUIPC: begin
                dec_a   = pc;
                dec_b   = imm_u;
                dec_ill = 1'b0;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_alu = ALU_ADD;
            dec_a   = '0;
            dec_b   = '0;
        end
    end

    // Output register: reset, then flush, then capture, then drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_control <= ALU_ADD;
            A           <= '0;
            B           <= '0;
            rd          <= '0;
            reg_write   <= 1'b0;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid   <= 1'b1;
            alu_control <= dec_alu;
            A           <= dec_a;
            B           <= dec_b;
            rd          <= rd_field;
            reg_write   <= !dec_ill && (rd_field != '0);
            illegal     <= dec_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized
// traffic checked against a behavioural model of the stage.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        v;
        logic [3:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t m;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
        .A(A), .B(B), .rd(rd), .reg_write(reg_write), .illegal(illegal)
    );

    function automatic exp_t got();
        return {out_valid, alu_control, A, B, rd, reg_write, illegal};
    endfunction

    function automatic logic [3:0] f3_code(input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        return tbl[f3];
    endfunction

    // What the ISA says a captured instruction should look like on the outputs
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        e = '0;
        e.v = 1'b1;
        e.rd = i[11:7];
        e.ill = 1'b1;
        if (op == 7'h33) begin
            e.a = r1;
            e.b = r2;
            if (f7 == 7'h00) begin e.ill = 1'b0; e.alu = f3_code(f3); end
            else if (f7 == 7'h20 && f3 == 3'd0) begin e.ill = 1'b0; e.alu = 4'd1; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 1'b0; e.alu = 4'd7; end
        end else if (op == 7'h13) begin
            e.a = r1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = 32'(i[24:20]);
                if (f7 == 7'h00) begin e.ill = 1'b0; e.alu = f3_code(f3); end
                else if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 1'b0; e.alu = 4'd7; end
            end else begin
                e.ill = 1'b0;
                e.alu = f3_code(f3);
                e.b = 32'($signed(i[31:20]));
            end
        end else if (op == 7'h37) begin
            e.ill = 1'b0;
            e.b = {i[31:12], 12'h000};
        end else if (op == 7'h17) begin
            e.ill = 1'b0;
            e.a = p;
            e.b = {i[31:12], 12'h000};
        end
        if (e.ill) begin
            e.alu = 4'd0;
            e.a = '0;
            e.b = '0;
        end
        e.rw = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic model_ready();
        return rst_n && (!m.v || out_ready);
    endfunction

    task automatic set_in(input logic v, input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic fl, input logic ordy);
        in_valid = v; instr = i; pc = p; rs1_data = d1; rs2_data = d2;
        flush = fl; out_ready = ordy;
    endtask

    // Advance one clock edge, updating the behavioural model with the inputs seen there
    task automatic tick();
        @(posedge clk);
        if (!rst_n) m = '0;
        else if (flush) m.v = 1'b0;
        else if (in_valid && (!m.v || out_ready)) m = ref_decode(instr, pc, rs1_data, rs2_data);
        else if (out_ready) m.v = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b1, 32'h002081B3, 32'h0, 32'd9, 32'd9, 1'b1, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready);
        end
        tick(); tick();
        checks++;
        if (got() !== exp_t'(0)) begin
            errors++; $display("FAIL reset_outputs: got %h exp 0", got());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        set_in(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b1);
        #1;
        checks++;
        if ({rs1_addr, rs2_addr, in_ready} !== {5'd1, 5'd2, 1'b1}) begin
            errors++; $display("FAIL add_addr: got %h/%h rdy %b exp 1/2 rdy 1", rs1_addr, rs2_addr, in_ready);
        end
        tick();
        checks++;
        if (got() !== {1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add: got %h", got());
        end
    endtask

    task automatic test_imm();
        set_in(1'b1, 32'hFFF0A093, 32'h0, 32'h11, 32'h22, 1'b0, 1'b1);
        tick();
        checks++;
        if (got() !== {1'b1, 4'd3, 32'h11, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL slti: got %h", got());
        end
        set_in(1'b1, 32'h4030D093, 32'h0, 32'h80000000, 32'h22, 1'b0, 1'b1);
        tick();
        checks++;
        if (got() !== {1'b1, 4'd7, 32'h80000000, 32'd3, 5'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL srai: got %h", got());
        end
    endtask

    task automatic test_upper();
        set_in(1'b1, 32'h12345037, 32'h40, 32'h55, 32'h66, 1'b0, 1'b1);
        tick();
        checks++;
        if (got() !== {1'b1, 4'd0, 32'h0, 32'h12345000, 5'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL lui: got %h", got());
        end
        set_in(1'b1, 32'h00001117, 32'h100, 32'h55, 32'h66, 1'b0, 1'b1);
        tick();
        checks++;
        if (got() !== {1'b1, 4'd0, 32'h100, 32'h1000, 5'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL auipc: got %h", got());
        end
    endtask

    task automatic test_illegal();
        set_in(1'b1, 32'h0000006F, 32'h200, 32'h55, 32'h66, 1'b0, 1'b1);
        tick();
        checks++;
        if (got() !== {1'b1, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL jal_illegal: got %h", got());
        end
        set_in(1'b1, 32'h02208033, 32'h200, 32'h55, 32'h66, 1'b0, 1'b1);
        tick();
        checks++;
        if (got() !== {1'b1, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL mul_illegal: got %h", got());
        end
    endtask

    task automatic test_stall();
        set_in(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 32'h407302B3, 32'h0, 32'd100, 32'd40, 1'b0, 1'b0);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_ready[%0d]: got %b exp 0", k, in_ready);
            end
            tick();
            checks++;
            if (got() !== {1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h", k, got());
            end
        end
        set_in(1'b1, 32'h407302B3, 32'h0, 32'd100, 32'd40, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready: got %b exp 1", in_ready);
        end
        tick();
        checks++;
        if (got() !== {1'b1, 4'd1, 32'd100, 32'd40, 5'd5, 1'b1, 1'b0}) begin
            errors++; $display("FAIL stall_second: got %h", got());
        end
        set_in(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checks++;
        if ({out_valid, rd, alu_control} !== {1'b0, 5'd5, 4'd1}) begin
            errors++; $display("FAIL drain: got v=%b rd=%0d alu=%h exp v=0 rd=5 alu=1", out_valid, rd, alu_control);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL no_duplicate: got %b exp 0", out_valid);
        end
    endtask

    task automatic test_flush();
        set_in(1'b1, 32'h00A00513, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b1);
        tick();
        checks++;
        if (got() !== {1'b0, 4'd0, 32'd1, 32'd10, 5'd10, 1'b1, 1'b0}) begin
            errors++; $display("FAIL flush: got %h", got());
        end
    endtask

    task automatic test_reset_mid_stall();
        set_in(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        set_in(1'b1, 32'h407302B3, 32'h0, 32'd100, 32'd40, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_stall_ready: got %b exp 0", in_ready);
        end
        tick();
        checks++;
        if (got() !== exp_t'(0)) begin
            errors++; $display("FAIL rst_stall_outputs: got %h exp 0", got());
        end
        rst_n = 1'b1;
        set_in(1'b0, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_no_replay: got %b exp 0", out_valid);
        end
        set_in(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        checks++;
        if (got() !== {1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL first_after_reset: got %h", got());
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        int unsigned sel;
        int unsigned f7sel;
        i = $urandom;
        sel = $urandom_range(0, 9);
        f7sel = $urandom_range(0, 3);
        if (sel <= 2) i[6:0] = 7'h33;
        else if (sel <= 5) i[6:0] = 7'h13;
        else if (sel == 6) i[6:0] = 7'h37;
        else if (sel == 7) i[6:0] = 7'h17;
        if (sel <= 5) begin
            if (f7sel <= 1) i[31:25] = 7'h00;
            else if (f7sel == 2) i[31:25] = 7'h20;
        end
        return i;
    endfunction

    task automatic test_random();
        m = '0;
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            set_in($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom, $urandom,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6);
            #1;
            checks++;
            if ({in_ready, rs1_addr, rs2_addr} !== {model_ready(), instr[19:15], instr[24:20]}) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got rdy=%b rs=%h/%h exp rdy=%b rs=%h/%h", n,
                         in_ready, rs1_addr, rs2_addr, model_ready(), instr[19:15], instr[24:20]);
            end
            tick();
            checks++;
            if (got() !== m) begin
                errors++; $display("FAIL rand_out[%0d]: instr %h got %h exp %h", n, instr, got(), m);
            end
        end
    endtask

    initial begin
        m = '0;
        test_reset();
        test_add();
        test_imm();
        test_upper();
        test_illegal();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
